// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential / branch / jump / return next-PC selection
// with a circular return-address stack that tracks overflow and underflow.
module pc_sequencer #(
  parameter int                PC_W      = 32,
  parameter int                BOFF_W    = 14,
  parameter int                JOFF_W    = 24,
  parameter int                RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]   RESET_VEC = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pc_write,
  input  logic [1:0]                         instr_type,
  input  logic [4:0]                         opcode,
  input  logic                               zero_signal,
  input  logic                               stop_bit,
  input  logic [BOFF_W-1:0]                  branch_offset,
  input  logic [JOFF_W-1:0]                  jump_offset,
  output logic [PC_W-1:0]                    pc,
  output logic [1:0]                         pc_src,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_full,
  output logic                               ras_empty,
  output logic                               ras_overflow,
  output logic                               ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [1:0] TYPE_I = 2'b01;
  localparam logic [1:0] TYPE_J = 2'b10;
  localparam logic [4:0] OP_BEQ  = 5'b00100;
  localparam logic [4:0] OP_BNE  = 5'b00101;
  localparam logic [4:0] OP_CALL = 5'b00001;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'b00,
    SRC_BR  = 2'b01,
    SRC_JMP = 2'b10,
    SRC_RET = 2'b11
  } pc_src_e;

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  logic            is_branch;
  logic            is_jump;
  logic            is_call;
  logic            do_push;
  logic            do_pop;
  pc_src_e         src_sel;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] next_pc;

  // Instruction decode
  assign is_branch = (instr_type == TYPE_I) &&
                     (((opcode == OP_BEQ) &&  zero_signal) ||
                      ((opcode == OP_BNE) && !zero_signal));
  assign is_jump   = (instr_type == TYPE_J);
  assign is_call   = is_jump && (opcode == OP_CALL);

  // A return request overrides a simultaneous call, so the call never pushes.
  assign do_push = pc_write && is_call && !stop_bit;
  assign do_pop  = pc_write && stop_bit;

  always_comb begin
    src_sel = SRC_SEQ;
    if (stop_bit)       src_sel = SRC_RET;
    else if (is_jump)   src_sel = SRC_JMP;
    else if (is_branch) src_sel = SRC_BR;
  end

  assign pc_src = src_sel;

  // Offsets are word offsets: sign-extend to PC width, then scale by 4.
  assign pc_plus4   = pc + PC_W'(4);
  assign br_target  = pc + (PC_W'($signed(branch_offset)) << 2);
  assign jmp_target = pc + (PC_W'($signed(jump_offset)) << 2);

  always_comb begin
    next_pc = pc_plus4;
    case (src_sel)
      SRC_SEQ: next_pc = pc_plus4;
      SRC_BR:  next_pc = br_target;
      SRC_JMP: next_pc = jmp_target;
      SRC_RET: next_pc = ras_empty ? pc_plus4 : ras_mem[top_ptr];
      default: next_pc = pc_plus4;
    endcase
  end

  // Top pointer wraps at RAS_DEPTH, which need not be a power of two.
  always_comb begin
    ptr_inc = top_ptr + PTR_W'(1);
    ptr_dec = top_ptr - PTR_W'(1);
    if (top_ptr == PTR_W'(RAS_DEPTH - 1)) ptr_inc = '0;
    if (top_ptr == '0)                    ptr_dec = PTR_W'(RAS_DEPTH - 1);
  end

  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
  assign ras_empty = (ras_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_VEC;
      top_ptr       <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (pc_write) begin
      pc <= next_pc;
      if (do_push) begin
        // When full the slot after the top holds the oldest entry; it gets overwritten.
        top_ptr <= ptr_inc;
        if (ras_full) ras_overflow <= 1'b1;
        else          ras_count    <= ras_count + CNT_W'(1);
      end else if (do_pop) begin
        if (ras_empty) begin
          ras_underflow <= 1'b1;
        end else begin
          top_ptr   <= ptr_dec;
          ras_count <= ras_count - CNT_W'(1);
        end
      end
    end
  end

  // Stack storage has no reset; its contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ptr_inc] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes hand-computed snapshots into a
// queue and a monitor compares them against the DUT whenever a sample is presented.
module tb_pc_sequencer;

  localparam int SNAP_W = 32 + 2 + 3 + 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic [1:0]  instr_type;
  logic [4:0]  opcode;
  logic        zero_signal;
  logic        stop_bit;
  logic [13:0] branch_offset;
  logic [23:0] jump_offset;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic [2:0]  ras_count;
  logic        ras_full;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ras_underflow;

  logic              sample = 1'b0;
  logic [SNAP_W-1:0] exp_q[$];
  string             name_q[$];
  int                checks = 0;
  int                passed = 0;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .instr_type    (instr_type),
    .opcode        (opcode),
    .zero_signal   (zero_signal),
    .stop_bit      (stop_bit),
    .branch_offset (branch_offset),
    .jump_offset   (jump_offset),
    .pc            (pc),
    .pc_src        (pc_src),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (sample) begin
      logic [SNAP_W-1:0] got;
      logic [SNAP_W-1:0] exp;
      string             nm;
      got = {pc, pc_src, ras_count, ras_full, ras_empty, ras_overflow, ras_underflow};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_sample: got %h, required none", got);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (got === exp) passed++;
        else $display("FAIL %s: got pc=%h src=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b, required pc=%h src=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                      nm, got[40:9], got[8:7], got[6:4], got[3], got[2], got[1], got[0],
                      exp[40:9], exp[8:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_snap(input string nm, input logic [31:0] epc, input logic [1:0] esrc,
                             input int ecnt, input logic eovf, input logic eunf);
    logic [2:0] c;
    c = 3'(ecnt);
    exp_q.push_back({epc, esrc, c, (ecnt == 4), (ecnt == 0), eovf, eunf});
    name_q.push_back(nm);
  endtask

  task automatic clear_inputs();
    pc_write      = 1'b0;
    instr_type    = 2'b00;
    opcode        = 5'b00000;
    zero_signal   = 1'b0;
    stop_bit      = 1'b0;
    branch_offset = '0;
    jump_offset   = '0;
  endtask

  // Inputs stay applied through the update edge and the following sample point.
  task automatic run_op(input string nm, input logic [1:0] it, input logic [4:0] opc,
                        input logic z, input logic stp, input int bo, input int jo,
                        input logic wr, input logic [31:0] epc, input logic [1:0] esrc,
                        input int ecnt, input logic eovf, input logic eunf);
    @(negedge clk);
    instr_type    = it;
    opcode        = opc;
    zero_signal   = z;
    stop_bit      = stp;
    branch_offset = bo[13:0];
    jump_offset   = jo[23:0];
    pc_write      = wr;
    expect_snap(nm, epc, esrc, ecnt, eovf, eunf);
    @(posedge clk);
    #1 sample = 1'b1;
    @(negedge clk);
    #1 sample = 1'b0;
    clear_inputs();
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #2 reset = 1'b1;
    expect_snap(nm, 32'h0, 2'b00, 0, 1'b0, 1'b0);
    #1 sample = 1'b1;
    @(negedge clk);
    #1 sample = 1'b0;
    reset = 1'b0;
  endtask

  task automatic reset_on_write_edge(input string nm);
    @(negedge clk);
    instr_type  = 2'b10;
    jump_offset = 24'd8;
    pc_write    = 1'b1;
    expect_snap(nm, 32'h0, 2'b10, 0, 1'b0, 1'b0);
    #4 reset = 1'b1;
    @(posedge clk);
    #1 sample = 1'b1;
    @(negedge clk);
    #1 sample = 1'b0;
    reset = 1'b0;
    clear_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    expect_snap("reset_state", 32'h0, 2'b00, 0, 1'b0, 1'b0);
    #2 sample = 1'b1;
    @(negedge clk);
    #1 sample = 1'b0;
    reset = 1'b0;

    // sequential stepping
    run_op("seq_1", 2'b00, 5'd0, 0, 0, 0, 0, 1, 32'h4, 2'b00, 0, 0, 0);
    run_op("seq_2", 2'b00, 5'd0, 0, 0, 0, 0, 1, 32'h8, 2'b00, 0, 0, 0);
    run_op("seq_3", 2'b00, 5'd0, 0, 0, 0, 0, 1, 32'hC, 2'b00, 0, 0, 0);

    // branches
    run_op("jmp_to_100",   2'b10, 5'd0,     0, 0, 0, 61, 1, 32'h100, 2'b10, 0, 0, 0);
    run_op("beq_taken",    2'b01, 5'b00100, 1, 0, -2, 0, 1, 32'hF8, 2'b01, 0, 0, 0);
    run_op("jmp_back_100", 2'b10, 5'd0,     0, 0, 0, 2,  1, 32'h100, 2'b10, 0, 0, 0);
    run_op("beq_not_taken",2'b01, 5'b00100, 0, 0, -2, 0, 1, 32'h104, 2'b00, 0, 0, 0);
    run_op("jmp_minus1",   2'b10, 5'd0,     0, 0, 0, -1, 1, 32'h100, 2'b10, 0, 0, 0);
    run_op("bne_taken",    2'b01, 5'b00101, 0, 0, 3, 0,  1, 32'h10C, 2'b01, 0, 0, 0);
    run_op("bne_not_taken",2'b01, 5'b00101, 1, 0, 3, 0,  1, 32'h110, 2'b00, 0, 0, 0);
    run_op("rtype_beq_op", 2'b00, 5'b00100, 1, 0, 3, 0,  1, 32'h114, 2'b00, 0, 0, 0);
    run_op("itype_other",  2'b01, 5'b00110, 1, 0, 3, 0,  1, 32'h118, 2'b00, 0, 0, 0);

    // call / return
    run_op("jmp_to_40",    2'b10, 5'd0, 0, 0, 0, -54,   1, 32'h40, 2'b10, 0, 0, 0);
    run_op("call_40",      2'b10, 5'd1, 0, 0, 0, 16,    1, 32'h80, 2'b10, 1, 0, 0);
    run_op("ret_to_44",    2'b00, 5'd0, 0, 1, 0, 0,     1, 32'h44, 2'b11, 0, 0, 0);
    run_op("call_44",      2'b10, 5'd1, 0, 0, 0, 4,     1, 32'h54, 2'b10, 1, 0, 0);

    // pc_write low holds everything while pc_src still follows inputs
    for (int i = 0; i < 10; i++)
      run_op($sformatf("hold_call_%0d", i), 2'b10, 5'd1, 0, 0, 0, 4, 0, 32'h54, 2'b10, 1, 0, 0);
    run_op("hold_stop",    2'b00, 5'd0, 0, 1, 0, 0,     0, 32'h54, 2'b11, 1, 0, 0);
    run_op("stop_with_call",2'b10,5'd1, 0, 1, 0, 4,     1, 32'h48, 2'b11, 0, 0, 0);

    // nested calls past the stack depth
    run_op("ncall_1", 2'b10, 5'd1, 0, 0, 0, 2, 1, 32'h50, 2'b10, 1, 0, 0);
    run_op("ncall_2", 2'b10, 5'd1, 0, 0, 0, 2, 1, 32'h58, 2'b10, 2, 0, 0);
    run_op("ncall_3", 2'b10, 5'd1, 0, 0, 0, 2, 1, 32'h60, 2'b10, 3, 0, 0);
    run_op("ncall_4", 2'b10, 5'd1, 0, 0, 0, 2, 1, 32'h68, 2'b10, 4, 0, 0);
    run_op("ncall_5", 2'b10, 5'd1, 0, 0, 0, 2, 1, 32'h70, 2'b10, 4, 1, 0);
    run_op("nret_5",  2'b00, 5'd0, 0, 1, 0, 0, 1, 32'h6C, 2'b11, 3, 1, 0);
    run_op("nret_4",  2'b00, 5'd0, 0, 1, 0, 0, 1, 32'h64, 2'b11, 2, 1, 0);
    run_op("nret_3",  2'b00, 5'd0, 0, 1, 0, 0, 1, 32'h5C, 2'b11, 1, 1, 0);
    run_op("nret_2",  2'b00, 5'd0, 0, 1, 0, 0, 1, 32'h54, 2'b11, 0, 1, 0);
    run_op("ret_empty",2'b00,5'd0, 0, 1, 0, 0, 1, 32'h58, 2'b11, 0, 1, 1);

    // wrap-around and reset behaviour
    run_op("jmp_to_top", 2'b10, 5'd0, 0, 0, 0, -23, 1, 32'hFFFFFFFC, 2'b10, 0, 1, 1);
    run_op("seq_wrap",   2'b00, 5'd0, 0, 0, 0, 0,   1, 32'h0,  2'b00, 0, 1, 1);
    run_op("call_at_0",  2'b10, 5'd1, 0, 0, 0, 4,   1, 32'h10, 2'b10, 1, 1, 1);
    async_reset_check("async_reset");
    run_op("seq_after_rst", 2'b00, 5'd0, 0, 0, 0, 0, 1, 32'h4, 2'b00, 0, 0, 0);
    reset_on_write_edge("reset_wins_edge");
    run_op("seq_after_rst2",2'b00, 5'd0, 0, 0, 0, 0, 1, 32'h4, 2'b00, 0, 0, 0);

    repeat (3) @(negedge clk);
    while (exp_q.size() != 0) begin
      checks++;
      $display("FAIL %s: got no sample, required one", name_q.pop_front());
      void'(exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
